// File: rtl/qspi_pkg.sv
// +------------------------------------------------------------------+
// | qspi_pkg : shared types and constants for the QSPI bus arbiter   |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
`default_nettype none

package qspi_pkg;

  localparam int QSPI_IO_W       = 4;
  localparam int TURN_CYCLES_DEF = 2;
  localparam int MAX_HOLD_DEF    = 4096;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_FL = 2'd1,
    OWN_PS = 2'd2,
    TURN   = 2'd3
  } state_e;

  typedef enum logic {
    FL = 1'b0,
    PS = 1'b1
  } owner_e;

  // Round-robin pick: on a tie the requester that did not own the bus last wins.
  function automatic state_e arbitrate(input logic fl_req, input logic ps_req,
                                       input owner_e last_owner);
    if (fl_req && ps_req) return (last_owner == PS) ? OWN_FL : OWN_PS;
    if (fl_req)           return OWN_FL;
    if (ps_req)           return OWN_PS;
    return IDLE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/qspi_pad_mux.sv
// +------------------------------------------------------------------+
// | qspi_pad_mux : combinational pad steering, safe values unless    |
// |                a controller owns the bus                         |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
`default_nettype none

module qspi_pad_mux
  import qspi_pkg::*;
(
  input  state_e               state_i,
  input  logic                 fl_ce_n_i,
  input  logic                 fl_sclk_i,
  input  logic [QSPI_IO_W-1:0] fl_io_out_i,
  input  logic [QSPI_IO_W-1:0] fl_io_oe_i,
  input  logic                 ps_ce_n_i,
  input  logic                 ps_sclk_i,
  input  logic [QSPI_IO_W-1:0] ps_io_out_i,
  input  logic [QSPI_IO_W-1:0] ps_io_oe_i,
  output logic                 pad_ce0_n_o,
  output logic                 pad_ce1_n_o,
  output logic                 pad_sclk_ps_o,
  output logic                 pad_sclk_fl_o,
  output logic [QSPI_IO_W-1:0] pad_io_out_o,
  output logic [QSPI_IO_W-1:0] pad_io_oe_o
);

  always_comb begin
    pad_ce0_n_o   = 1'b1;
    pad_ce1_n_o   = 1'b1;
    pad_sclk_ps_o = 1'b0;
    pad_sclk_fl_o = 1'b0;
    pad_io_out_o  = '0;
    pad_io_oe_o   = '0;
    case (state_i)
      OWN_FL: begin
        pad_ce1_n_o   = fl_ce_n_i;
        pad_sclk_fl_o = fl_sclk_i;
        pad_io_out_o  = fl_io_out_i;
        pad_io_oe_o   = fl_io_oe_i;
      end
      OWN_PS: begin
        pad_ce0_n_o   = ps_ce_n_i;
        pad_sclk_ps_o = ps_sclk_i;
        pad_io_out_o  = ps_io_out_i;
        pad_io_oe_o   = ps_io_oe_i;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/qspi_bus_arbiter.sv
// +------------------------------------------------------------------+
// | qspi_bus_arbiter : round-robin owner of the shared QSPI pins     |
// |   with guaranteed idle turnaround. Optional grant-hold timeout   |
// |   enabled by defining QSPI_ARB_TIMEOUT_EN.                       |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
`default_nettype none

module qspi_bus_arbiter
  import qspi_pkg::*;
#(
  parameter int TURN_CYCLES = TURN_CYCLES_DEF,
  parameter int MAX_HOLD    = MAX_HOLD_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fl_req_i,
  output logic                 fl_gnt_o,
  input  logic                 fl_ce_n_i,
  input  logic                 fl_sclk_i,
  input  logic [QSPI_IO_W-1:0] fl_io_out_i,
  input  logic [QSPI_IO_W-1:0] fl_io_oe_i,
  input  logic                 ps_req_i,
  output logic                 ps_gnt_o,
  input  logic                 ps_ce_n_i,
  input  logic                 ps_sclk_i,
  input  logic [QSPI_IO_W-1:0] ps_io_out_i,
  input  logic [QSPI_IO_W-1:0] ps_io_oe_i,
  output logic                 pad_ce0_n_o,
  output logic                 pad_ce1_n_o,
  output logic                 pad_sclk_ps_o,
  output logic                 pad_sclk_fl_o,
  output logic [QSPI_IO_W-1:0] pad_io_out_o,
  output logic [QSPI_IO_W-1:0] pad_io_oe_o,
  input  logic [QSPI_IO_W-1:0] pad_io_in_i,
  output logic [QSPI_IO_W-1:0] io_in_o,
  output logic                 timeout_err_o
);

  if (TURN_CYCLES < 1 || TURN_CYCLES > 15 || MAX_HOLD < 16 || MAX_HOLD > 65535) begin : g_param_check
    $error("qspi_bus_arbiter: TURN_CYCLES or MAX_HOLD out of range");
  end

  localparam logic [3:0] c_TURN_LOAD = 4'(TURN_CYCLES - 1);

  state_e     state_q, state_d;
  owner_e     last_q, last_d;
  logic [3:0] turn_q, turn_d;
  logic       fl_gnt_q, ps_gnt_q;

`ifdef QSPI_ARB_TIMEOUT_EN
  localparam logic [15:0] c_HOLD_LIM = 16'(MAX_HOLD - 1);
  logic [15:0] hold_q, hold_d;
  logic        tmo_q, tmo_d;
  logic        hold_lim;
  assign hold_lim = (hold_q >= c_HOLD_LIM);
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    turn_d  = turn_q;
`ifdef QSPI_ARB_TIMEOUT_EN
    tmo_d   = 1'b0;
`endif
    case (state_q)
      IDLE: state_d = arbitrate(fl_req_i, ps_req_i, last_q);
      OWN_FL: begin
        if (!fl_req_i && fl_ce_n_i) begin
          state_d = TURN;
          turn_d  = c_TURN_LOAD;
          last_d  = FL;
        end
`ifdef QSPI_ARB_TIMEOUT_EN
        else if (hold_lim && ps_req_i) begin
          state_d = TURN;
          turn_d  = c_TURN_LOAD;
          last_d  = FL;
          tmo_d   = 1'b1;
        end
`endif
      end
      OWN_PS: begin
        if (!ps_req_i && ps_ce_n_i) begin
          state_d = TURN;
          turn_d  = c_TURN_LOAD;
          last_d  = PS;
        end
`ifdef QSPI_ARB_TIMEOUT_EN
        else if (hold_lim && fl_req_i) begin
          state_d = TURN;
          turn_d  = c_TURN_LOAD;
          last_d  = PS;
          tmo_d   = 1'b1;
        end
`endif
      end
      TURN: begin
        // Final turnaround cycle doubles as IDLE so a waiting requester sees no bubble.
        if (turn_q == 4'd0) state_d = arbitrate(fl_req_i, ps_req_i, last_q);
        else                turn_d  = turn_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef QSPI_ARB_TIMEOUT_EN
  always_comb begin
    hold_d = 16'd0;
    if (state_q == OWN_FL || state_q == OWN_PS)
      hold_d = (hold_q == 16'hFFFF) ? hold_q : hold_q + 16'd1;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= PS;
      turn_q   <= 4'd0;
      fl_gnt_q <= 1'b0;
      ps_gnt_q <= 1'b0;
`ifdef QSPI_ARB_TIMEOUT_EN
      hold_q   <= 16'd0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      turn_q   <= turn_d;
      fl_gnt_q <= (state_d == OWN_FL);
      ps_gnt_q <= (state_d == OWN_PS);
`ifdef QSPI_ARB_TIMEOUT_EN
      hold_q   <= hold_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign fl_gnt_o = fl_gnt_q;
  assign ps_gnt_o = ps_gnt_q;
  assign io_in_o  = pad_io_in_i;

`ifdef QSPI_ARB_TIMEOUT_EN
  assign timeout_err_o = tmo_q;
`else
  assign timeout_err_o = 1'b0;
`endif

  qspi_pad_mux u_pad_mux (
    .state_i       (state_q),
    .fl_ce_n_i     (fl_ce_n_i),
    .fl_sclk_i     (fl_sclk_i),
    .fl_io_out_i   (fl_io_out_i),
    .fl_io_oe_i    (fl_io_oe_i),
    .ps_ce_n_i     (ps_ce_n_i),
    .ps_sclk_i     (ps_sclk_i),
    .ps_io_out_i   (ps_io_out_i),
    .ps_io_oe_i    (ps_io_oe_i),
    .pad_ce0_n_o   (pad_ce0_n_o),
    .pad_ce1_n_o   (pad_ce1_n_o),
    .pad_sclk_ps_o (pad_sclk_ps_o),
    .pad_sclk_fl_o (pad_sclk_fl_o),
    .pad_io_out_o  (pad_io_out_o),
    .pad_io_oe_o   (pad_io_oe_o)
  );

endmodule

`default_nettype wire

// File: doc/qspi_bus_arbiter.md
Name: qspi_bus_arbiter

Overview:
- Shares the single quad-SPI pin set (io0..io3 plus the two chip-enables and the two SPI clocks) between the NOR-flash controller and the PSRAM controller inside the SoC.
- Fair round-robin grant.
- Guaranteed idle turnaround between owners, so neither device can see a clock or driven IO while deselected.
- Sits between both memory controllers and the uio pads.

Parameters:
- TURN_CYCLES, 2: idle cycles (both CE high, io_oe=0) between one owner's release and the next grant; legal 1..15.
- MAX_HOLD, 4096: grant-hold limit in cycles, used only with the optional feature; legal 16..65535.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- fl_req  in  1  flash controller requests the bus
- fl_gnt  out  1  flash controller owns the bus
- fl_ce_n  in  1  flash chip-enable from its controller
- fl_sclk  in  1  flash SPI clock
- fl_io_out  in  4  flash IO drive values
- fl_io_oe  in  4  flash IO enables
- ps_req  in  1  PSRAM controller requests the bus
- ps_gnt  out  1  PSRAM controller owns the bus
- ps_ce_n  in  1  PSRAM chip-enable
- ps_sclk  in  1  PSRAM SPI clock
- ps_io_out  in  4  PSRAM IO drive values
- ps_io_oe  in  4  PSRAM IO enables
- pad_ce0_n  out  1  PSRAM chip-enable pad
- pad_ce1_n  out  1  flash chip-enable pad
- pad_sclk_ps  out  1  PSRAM clock pad
- pad_sclk_fl  out  1  flash clock pad
- pad_io_out  out  4  shared IO drive
- pad_io_oe  out  4  shared IO enable
- pad_io_in  in  4  shared IO sampled value
- io_in  out  4  pad_io_in, broadcast unmodified to both controllers
- timeout_err  out  1  one-cycle pulse on forced revoke (optional feature; tied 0 otherwise)

Behaviour:
- State machine IDLE, OWN_FL, OWN_PS, TURN.
- Registered state plus a last_owner bit.
- fl_gnt/ps_gnt are registered and decoded from the state.
- Reset values (asynchronous):
  - state = IDLE, last_owner = PS, so flash wins the first contest (boot fetch).
  - fl_gnt = ps_gnt = 0, pad_ce0_n = pad_ce1_n = 1, pad_sclk_* = 0, pad_io_oe = 0, pad_io_out = 0, timeout_err = 0, turn counter = 0.
- IDLE:
  - Exactly one req high: grant that requester next cycle (req to gnt = 1 cycle).
  - Both high: grant the one that is not last_owner.
  - Neither high: stay.
- OWN_x:
  - Pads driven combinationally from the owner's inputs; the non-owner's CE pad is held 1 and its sclk pad held 0.
  - Exit to TURN when x_req == 0 AND x_ce_n == 1 in the same cycle.
  - If req drops while ce_n == 0, hold ownership until ce_n rises; a transaction is never cut.
  - Update last_owner = x on exit.
  - gnt deasserts the cycle after exit.
- TURN:
  - Both CE pads 1, both sclk pads 0, pad_io_oe = 0.
  - Counter loads TURN_CYCLES-1 on entry and decrements to 0, so exactly TURN_CYCLES cycles are spent in TURN.
  - Then go to IDLE, with IDLE evaluated in the same cycle: a waiting requester is granted with no extra bubble.
- pad_io_oe/out in IDLE and TURN: 0.
- Owner CE/IO while gnt is low: ignored. A controller asserting ce_n = 0 without gnt has no effect on the pads.
- Back-to-back requests from the same owner with the other idle: still pass through TURN (uniform timing).
- Simultaneous release by the owner and request by the other requester: TURN, then the other requester is granted.
- Reset mid-transaction: pads go safe immediately; no state is preserved.

Optional Feature:
- Macro QSPI_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit hold counter clears on every grant and increments each OWN_x cycle.
  - When it reaches MAX_HOLD while the other requester's req == 1, force state to TURN regardless of ce_n.
  - The CE pad rises at that edge.
  - timeout_err pulses for 1 cycle and last_owner is updated.
- Undefined: no counter; timeout_err is a constant 0; ownership is unbounded.

Decomposition:
- Shared package qspi_pkg:
  - state encoding enum (IDLE=0, OWN_FL=1, OWN_PS=2, TURN=3)
  - owner enum (FL=0, PS=1)
  - QSPI_IO_W = 4
  - default TURN_CYCLES constant
- One sub-module, qspi_pad_mux: the purely combinational pad steering from state plus both controllers' signals, with safe values in IDLE/TURN.
- The FSM and counters stay in the top module.

Test Plan:
- Reset release, fl_req=1 at cycle 5 → fl_gnt=1 at cycle 6; pad_ce1_n follows fl_ce_n; pad_ce0_n stays 1, pad_sclk_ps stays 0.
- fl_req and ps_req both rise in the same cycle from reset → flash granted first. After flash releases (req=0, ce_n=1), exactly 2 TURN cycles with pad_io_oe=0, then ps_gnt=1.
- PSRAM owner drops ps_req while ps_ce_n=0 for 10 more cycles → ps_gnt stays 1 until ce_n rises; TURN starts the cycle after.
- ps_gnt=0 while ps_ce_n=0 and ps_io_oe=4'hF → pads remain ce0_n=1, io_oe=0.
- QSPI_ARB_TIMEOUT_EN with MAX_HOLD=16: flash holds ce_n=0 indefinitely while ps_req=1 → after 16 owned cycles pad_ce1_n=1, timeout_err pulses once, ps_gnt=1 after TURN.
- Assert rst mid-PSRAM transfer → same-cycle (asynchronous) pad_ce0_n=1, pad_io_oe=0, both gnt=0.
